// File: rtl/accum_cpu_pkg.sv
// Shared types and encodings for the accumulator-computer control sequencer.
// Opcodes, FSM states, decode classes, ALU opcodes and datapath mux selects.
package accum_cpu_pkg;

    typedef enum logic [3:0] {
        OP_HALT  = 4'h0,
        OP_LOAD  = 4'h1,
        OP_STORE = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_XOR   = 4'h7,
        OP_JUMP  = 4'h8,
        OP_JZ    = 4'h9,
        OP_JNEG  = 4'hA,
        OP_SHL   = 4'hB,
        OP_SHR   = 4'hC,
        OP_CLEAR = 4'hD,
        OP_ILL_E = 4'hE,
        OP_ILL_F = 4'hF
    } opcode_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_F0,
        S_F1,
        S_F2,
        S_DECODE,
        S_EA,
        S_EM,
        S_EB,
        S_EX,
        S_SW,
        S_HALT
    } state_e;

    // How DECODE dispatches an instruction
    typedef enum logic [2:0] {
        CLS_ONE,
        CLS_MEMRD,
        CLS_STORE,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_e;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SHL = 4'b0100;
    localparam logic [3:0] ALU_SHR = 4'b0101;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;
    localparam logic [3:0] ALU_XOR = 4'b1010;

    localparam logic [1:0] ACC_SEL_ALU  = 2'd0;
    localparam logic [1:0] ACC_SEL_MBR  = 2'd1;
    localparam logic [1:0] ACC_SEL_ZERO = 2'd2;

    localparam logic PC_SEL_INC = 1'b0;
    localparam logic PC_SEL_IR  = 1'b1;

    localparam logic MAR_SEL_PC = 1'b0;
    localparam logic MAR_SEL_IR = 1'b1;

endpackage

// File: rtl/accum_cpu_controller_instr_decode.sv
// Combinational opcode decoder: dispatch class plus the ALU opcode the
// instruction needs (ADD when the instruction does not use the ALU).
module instr_decode
    import accum_cpu_pkg::*;
(
    input  opcode_e     opcode,
    output op_class_e   op_class,
    output logic [3:0]  alu_op
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        alu_op   = ALU_ADD;
        case (opcode)
            OP_HALT:  op_class = CLS_HALT;
            OP_LOAD:  op_class = CLS_MEMRD;
            OP_STORE: op_class = CLS_STORE;
            OP_ADD: begin
                op_class = CLS_MEMRD;
                alu_op   = ALU_ADD;
            end
            OP_SUB: begin
                op_class = CLS_MEMRD;
                alu_op   = ALU_SUB;
            end
            OP_AND: begin
                op_class = CLS_MEMRD;
                alu_op   = ALU_AND;
            end
            OP_OR: begin
                op_class = CLS_MEMRD;
                alu_op   = ALU_OR;
            end
            OP_XOR: begin
                op_class = CLS_MEMRD;
                alu_op   = ALU_XOR;
            end
            OP_JUMP, OP_JZ, OP_JNEG, OP_CLEAR: op_class = CLS_ONE;
            OP_SHL: begin
                op_class = CLS_ONE;
                alu_op   = ALU_SHL;
            end
            OP_SHR: begin
                op_class = CLS_ONE;
                alu_op   = ALU_SHR;
            end
            default:  op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/accum_cpu_controller.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit accumulator
// computer; drives register strobes, mux selects, ALU opcode and mem_we.
module accum_cpu_controller
    import accum_cpu_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int OPERAND_W = 12,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              step_mode,
    input  logic [DATA_W-1:0] ir_in,
    input  logic              acc_zero,
    input  logic              acc_neg,
    output logic              pc_we,
    output logic              mar_we,
    output logic              mbr_we,
    output logic              ir_we,
    output logic              acc_we,
    output logic              pc_sel,
    output logic              mar_sel,
    output logic [1:0]        acc_sel,
    output logic [3:0]        alu_op,
    output logic              mem_we,
    output logic              busy,
    output logic              halted,
    output logic              illegal,
    output logic [CNT_W-1:0]  instr_count
);

    state_e     state, next_state, retire_state;
    opcode_e    ir_op, op_q;
    op_class_e  dec_class;
    logic [3:0] dec_alu, alu_q;
    logic       step_q, illegal_q, retire, set_illegal;
    logic [CNT_W-1:0] count_q;

    // The operand field is consumed by the datapath muxes, not here
    logic unused_operand;
    assign unused_operand = ^ir_in[OPERAND_W-1:0];

    assign ir_op = opcode_e'(ir_in[DATA_W-1 -: 4]);

    instr_decode u_decode (
        .opcode   (ir_op),
        .op_class (dec_class),
        .alu_op   (dec_alu)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            step_q    <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= '0;
            op_q      <= OP_HALT;
            alu_q     <= ALU_ADD;
        end else begin
            state <= next_state;
            if (state == S_IDLE && start)
                step_q <= step_mode;
            // Hold the opcode so EA/EX do not depend on IR staying put
            if (state == S_DECODE) begin
                op_q  <= ir_op;
                alu_q <= dec_alu;
            end
            if (set_illegal)
                illegal_q <= 1'b1;
            if (retire)
                count_q <= count_q + CNT_W'(1);
        end
    end

    assign retire_state = step_q ? S_IDLE : S_F0;

    always_comb begin
        next_state  = state;
        pc_we       = 1'b0;
        mar_we      = 1'b0;
        mbr_we      = 1'b0;
        ir_we       = 1'b0;
        acc_we      = 1'b0;
        pc_sel      = PC_SEL_INC;
        mar_sel     = MAR_SEL_PC;
        acc_sel     = ACC_SEL_ALU;
        alu_op      = ALU_ADD;
        mem_we      = 1'b0;
        halted      = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        case (state)
            S_IDLE: if (start) next_state = S_F0;
            S_F0: begin
                mar_we     = 1'b1;
                mar_sel    = MAR_SEL_PC;
                next_state = S_F1;
            end
            S_F1: next_state = S_F2;
            S_F2: begin
                ir_we      = 1'b1;
                pc_we      = 1'b1;
                pc_sel     = PC_SEL_INC;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                case (dec_class)
                    CLS_HALT: next_state = S_HALT;
                    CLS_ILLEGAL: begin
                        set_illegal = 1'b1;
                        next_state  = S_HALT;
                    end
                    CLS_MEMRD, CLS_STORE: next_state = S_EA;
                    default: begin
                        retire     = 1'b1;
                        next_state = retire_state;
                        case (ir_op)
                            OP_JUMP: begin
                                pc_we  = 1'b1;
                                pc_sel = PC_SEL_IR;
                            end
                            OP_JZ: begin
                                pc_we  = acc_zero;
                                pc_sel = acc_zero ? PC_SEL_IR : PC_SEL_INC;
                            end
                            OP_JNEG: begin
                                pc_we  = acc_neg;
                                pc_sel = acc_neg ? PC_SEL_IR : PC_SEL_INC;
                            end
                            OP_CLEAR: begin
                                acc_we  = 1'b1;
                                acc_sel = ACC_SEL_ZERO;
                            end
                            default: begin
                                acc_we  = 1'b1;
                                acc_sel = ACC_SEL_ALU;
                                alu_op  = dec_alu;
                            end
                        endcase
                    end
                endcase
            end
            S_EA: begin
                mar_we     = 1'b1;
                mar_sel    = MAR_SEL_IR;
                next_state = (op_q == OP_STORE) ? S_SW : S_EM;
            end
            S_EM: next_state = S_EB;
            S_EB: begin
                mbr_we     = 1'b1;
                next_state = S_EX;
            end
            S_EX: begin
                acc_we     = 1'b1;
                retire     = 1'b1;
                next_state = retire_state;
                if (op_q == OP_LOAD) begin
                    acc_sel = ACC_SEL_MBR;
                end else begin
                    acc_sel = ACC_SEL_ALU;
                    alu_op  = alu_q;
                end
            end
            S_SW: begin
                mem_we     = 1'b1;
                retire     = 1'b1;
                next_state = retire_state;
            end
            S_HALT: halted = 1'b1;
            default: next_state = S_IDLE;
        endcase
    end

    assign busy        = (state != S_IDLE) && (state != S_HALT);
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_accum_cpu_controller.sv
// Directed bench for accum_cpu_controller: walks each instruction class
// cycle by cycle and compares every control output against hand values.
module tb_accum_cpu_controller;

    logic        clk, reset_n, start, step_mode, acc_zero, acc_neg;
    logic [15:0] ir_in;
    logic        pc_we, mar_we, mbr_we, ir_we, acc_we, pc_sel, mar_sel, mem_we;
    logic        busy, halted, illegal;
    logic [1:0]  acc_sel;
    logic [3:0]  alu_op;
    logic [15:0] instr_count;
    logic [16:0] obs;

    int nchk = 0;
    int nerr = 0;

    // Bit positions within obs
    localparam logic [16:0] PCW  = 17'h10000;
    localparam logic [16:0] MARW = 17'h08000;
    localparam logic [16:0] MBRW = 17'h04000;
    localparam logic [16:0] IRW  = 17'h02000;
    localparam logic [16:0] ACCW = 17'h01000;
    localparam logic [16:0] PCS  = 17'h00800;
    localparam logic [16:0] MARS = 17'h00400;
    localparam logic [16:0] AMBR = 17'h00100;
    localparam logic [16:0] AZER = 17'h00200;
    localparam logic [16:0] ASUB = 17'h00010;
    localparam logic [16:0] ASHL = 17'h00040;
    localparam logic [16:0] MEMW = 17'h00008;
    localparam logic [16:0] BUSY = 17'h00004;
    localparam logic [16:0] HLT  = 17'h00002;
    localparam logic [16:0] ILL  = 17'h00001;

    accum_cpu_controller dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .step_mode   (step_mode),
        .ir_in       (ir_in),
        .acc_zero    (acc_zero),
        .acc_neg     (acc_neg),
        .pc_we       (pc_we),
        .mar_we      (mar_we),
        .mbr_we      (mbr_we),
        .ir_we       (ir_we),
        .acc_we      (acc_we),
        .pc_sel      (pc_sel),
        .mar_sel     (mar_sel),
        .acc_sel     (acc_sel),
        .alu_op      (alu_op),
        .mem_we      (mem_we),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    assign obs = {pc_we, mar_we, mbr_we, ir_we, acc_we, pc_sel, mar_sel,
                  acc_sel, alu_op, mem_we, busy, halted, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [16:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s outputs=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] exp);
        nchk++;
        assert (instr_count === exp)
        else begin
            nerr++;
            $error("FAIL %s instr_count=%0d expected=%0d", tag, instr_count, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; step_mode = 1'b0;
        ir_in = 16'h0000; acc_zero = 1'b0; acc_neg = 1'b0;
        tick(2);
        chk("reset", '0);
        chk_cnt("reset_cnt", 16'd0);
        reset_n = 1'b1;
        tick();
        chk("idle", '0);

        // LOAD 0x005: 8 cycles
        ir_in = 16'h1005; start = 1'b1;
        tick(); start = 1'b0;
        chk("ld_f0", MARW | BUSY);
        tick(); chk("ld_f1", BUSY);
        tick(); chk("ld_f2", IRW | PCW | BUSY);
        tick(); chk("ld_dec", BUSY);
        tick(); chk("ld_ea", MARW | MARS | BUSY);
        tick(); chk("ld_em", BUSY);
        tick(); chk("ld_eb", MBRW | BUSY);
        tick(); chk("ld_ex", ACCW | AMBR | BUSY);
        chk_cnt("ld_cnt_pre", 16'd0);
        tick(); chk("ld_next_f0", MARW | BUSY);
        chk_cnt("ld_cnt", 16'd1);

        // ADD then SUB, free-running
        ir_in = 16'h3010;
        tick(7); chk("add_ex", ACCW | BUSY);
        tick(); chk("add_next_f0", MARW | BUSY);
        chk_cnt("add_cnt", 16'd2);
        ir_in = 16'h4011;
        start = 1'b1;             // ignored while busy
        tick(7); chk("sub_ex", ACCW | ASUB | BUSY);
        start = 1'b0;
        tick(); chk("sub_next_f0", MARW | BUSY);
        chk_cnt("sub_cnt", 16'd3);

        // STORE: 6 cycles
        ir_in = 16'h2020;
        tick(3); chk("st_dec", BUSY);
        tick(); chk("st_ea", MARW | MARS | BUSY);
        tick(); chk("st_sw", MEMW | BUSY);
        tick(); chk("st_next_f0", MARW | BUSY);
        chk_cnt("st_cnt", 16'd4);

        // Branches and one-cycle ops: 4 cycles
        ir_in = 16'h9040; acc_zero = 1'b1;
        tick(3); chk("jz_taken", PCW | PCS | BUSY);
        tick(); chk("jz_next_f0", MARW | BUSY);
        acc_zero = 1'b0;
        tick(3); chk("jz_not_taken", BUSY);
        tick(); chk_cnt("jz_cnt", 16'd6);
        ir_in = 16'hA040; acc_neg = 1'b1;
        tick(3); chk("jneg_taken", PCW | PCS | BUSY);
        acc_neg = 1'b0;
        tick(); chk("jneg_next_f0", MARW | BUSY);
        ir_in = 16'h8123;
        tick(3); chk("jump", PCW | PCS | BUSY);
        tick();
        ir_in = 16'hB000;
        tick(3); chk("shl", ACCW | ASHL | BUSY);
        tick(); chk_cnt("shl_cnt", 16'd9);

        // Async reset in the middle of a STORE write cycle
        ir_in = 16'h2020;
        tick(5); chk("st2_sw", MEMW | BUSY);
        #2 reset_n = 1'b0;
        #1 chk("rst_mid_sw", '0);
        chk_cnt("rst_mid_cnt", 16'd0);
        tick(); reset_n = 1'b1;

        // Step mode: CLEAR then back to IDLE
        ir_in = 16'hD000; step_mode = 1'b1; start = 1'b1;
        tick(); start = 1'b0; step_mode = 1'b0;
        chk("step_f0", MARW | BUSY);
        tick(3); chk("clear", ACCW | AZER | BUSY);
        tick(); chk("step_idle", '0);
        chk_cnt("step_cnt", 16'd1);
        tick(2); chk("step_idle_hold", '0);

        // Illegal opcode
        ir_in = 16'hE000; step_mode = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        tick(3); chk("ill_dec", BUSY);
        tick(); chk("ill_halt", HLT | ILL);
        chk_cnt("ill_cnt", 16'd1);
        start = 1'b1;
        tick(3); chk("ill_start_ignored", HLT | ILL);
        start = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk("ill_reset", '0);
        tick(); reset_n = 1'b1;

        // HALT opcode
        ir_in = 16'h0000; start = 1'b1;
        tick(); start = 1'b0;
        tick(4); chk("halt", HLT);
        chk_cnt("halt_cnt", 16'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
